// File: rtl/hanoi_disp_pkg.sv
// Shared display definitions for the Hanoi-tower VGA overlay blocks.
// Holds the screen geometry, the RGB444 colour type, the size of the
// "break record time" banner bitmap and the banner sequencer state enum.
package hanoi_disp_pkg;

  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;

  localparam int BANNER_ROWS = 24;
  localparam int BANNER_COLS = 264;

  typedef logic [11:0] rgb444_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLINK = 2'd1,
    HOLD  = 2'd2
  } banner_state_t;

endpackage

// File: rtl/banner_pix_fetch.sv
// Two-stage window / index / bit-select pipeline for the record banner.
// Stage 1 decides whether the raster is inside the banner window and
// captures the row/column offsets; stage 2 selects the bitmap bit and
// gates it with the sequencer's visible flag.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   video_on          raster inside the visible area
//   pixel_x, pixel_y  raster coordinates
//   visible           banner visible flag from the sequencer (stage 2 only)
//   pixels            flat bitmap, row 0 first, column 0 is the row MSB
//   banner_pix        registered lit-pixel flag (2 cycles after inputs)
//   banner_rgb        registered colour, COLOR when banner_pix else 0
module banner_pix_fetch
  import hanoi_disp_pkg::*;
#(
  parameter int      ROWS  = BANNER_ROWS,
  parameter int      COLS  = BANNER_COLS,
  parameter int      ORG_X = 188,
  parameter int      ORG_Y = 228,
  parameter rgb444_t COLOR = 12'hFF0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   video_on,
  input  logic [9:0]             pixel_x,
  input  logic [9:0]             pixel_y,
  input  logic                   visible,
  input  logic [ROWS*COLS-1:0]   pixels,
  output logic                   banner_pix,
  output rgb444_t                banner_rgb
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int IW = $clog2(ROWS * COLS);

  localparam logic [9:0] X_LO = 10'(ORG_X);
  localparam logic [9:0] X_HI = 10'(ORG_X + COLS);
  localparam logic [9:0] Y_LO = 10'(ORG_Y);
  localparam logic [9:0] Y_HI = 10'(ORG_Y + ROWS);

  logic          in_win_d, in_win_q;
  logic [RW-1:0] r_d, r_q;
  logic [CW-1:0] c_d, c_q;
  logic [IW-1:0] bit_idx;
  logic          pix_d, pix_q;
  rgb444_t       rgb_d, rgb_q;

  always_comb begin
    in_win_d = video_on &&
               (pixel_x >= X_LO) && (pixel_x < X_HI) &&
               (pixel_y >= Y_LO) && (pixel_y < Y_HI);
    // Offsets are only meaningful inside the window; outside they are
    // truncated garbage that stage 2 never uses for indexing.
    r_d = RW'(pixel_y - Y_LO);
    c_d = CW'(pixel_x - X_LO);

    bit_idx = '0;
    pix_d   = 1'b0;
    if (in_win_q) begin
      // Column 0 is the MSB of its row, hence the reversed column term.
      bit_idx = IW'(r_q) * IW'(COLS) + IW'(COLS - 1) - IW'(c_q);
      pix_d   = visible && pixels[bit_idx];
    end
    rgb_d = pix_d ? COLOR : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_win_q <= 1'b0;
      r_q      <= '0;
      c_q      <= '0;
      pix_q    <= 1'b0;
      rgb_q    <= '0;
    end else begin
      in_win_q <= in_win_d;
      r_q      <= r_d;
      c_q      <= c_d;
      pix_q    <= pix_d;
      rgb_q    <= rgb_d;
    end
  end

  assign banner_pix = pix_q;
  assign banner_rgb = rgb_q;

endmodule

// File: rtl/record_banner_ctrl.sv
// Record banner sequencer: on a new-record pulse runs a frame-counted
// show sequence (blink, steady hold, off) and drives the banner pixel
// pipeline that overlays the 24x264 bitmap on the raster.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   new_record        pulse; starts or restarts the sequence
//   frame_start       pulse at the first cycle of each frame
//   video_on          raster inside the visible area
//   pixel_x, pixel_y  raster coordinates
//   pixels            flat bitmap from the ROM
//   banner_pix        registered lit-pixel flag
//   banner_rgb        registered pixel colour
//   banner_busy       sequence in BLINK or HOLD
module record_banner_ctrl
  import hanoi_disp_pkg::*;
#(
  parameter int      ROWS         = BANNER_ROWS,
  parameter int      COLS         = BANNER_COLS,
  parameter int      ORG_X        = 188,
  parameter int      ORG_Y        = 228,
  parameter int      BLINK_FRAMES = 120,
  parameter int      BLINK_HALF   = 15,
  parameter int      HOLD_FRAMES  = 180,
  parameter rgb444_t COLOR        = 12'hFF0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 new_record,
  input  logic                 frame_start,
  input  logic                 video_on,
  input  logic [9:0]           pixel_x,
  input  logic [9:0]           pixel_y,
  input  logic [ROWS*COLS-1:0] pixels,
  output logic                 banner_pix,
  output logic [11:0]          banner_rgb,
  output logic                 banner_busy
);

  localparam int FMAX = (BLINK_FRAMES > HOLD_FRAMES) ? BLINK_FRAMES : HOLD_FRAMES;
  localparam int FW   = $clog2(FMAX + 1);
  localparam int PW   = $clog2(BLINK_HALF + 1);

  banner_state_t state_d, state_q;
  logic [FW-1:0] frame_d, frame_q, frame_inc;
  logic [PW-1:0] phase_d, phase_q, phase_inc;
  logic          visible_d, visible_q;
  logic          busy_d, busy_q;

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    phase_d   = phase_q;
    visible_d = visible_q;
    frame_inc = frame_q + 1'b1;
    phase_inc = phase_q + 1'b1;

    // new_record has priority so a coincident frame_start is not counted.
    if (new_record) begin
      state_d   = BLINK;
      frame_d   = '0;
      phase_d   = '0;
      visible_d = 1'b1;
    end else if (frame_start) begin
      case (state_q)
        BLINK: begin
          frame_d = frame_inc;
          phase_d = phase_inc;
          if (phase_inc == PW'(BLINK_HALF)) begin
            visible_d = ~visible_q;
            phase_d   = '0;
          end
          // End of blink overrides any toggle on the same frame.
          if (frame_inc == FW'(BLINK_FRAMES)) begin
            state_d   = HOLD;
            frame_d   = '0;
            phase_d   = '0;
            visible_d = 1'b1;
          end
        end
        HOLD: begin
          frame_d   = frame_inc;
          visible_d = 1'b1;
          if (frame_inc == FW'(HOLD_FRAMES)) begin
            state_d   = IDLE;
            frame_d   = '0;
            visible_d = 1'b0;
          end
        end
        default: ;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      phase_q   <= '0;
      visible_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      phase_q   <= phase_d;
      visible_q <= visible_d;
      busy_q    <= busy_d;
    end
  end

  assign banner_busy = busy_q;

  banner_pix_fetch #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .ORG_X (ORG_X),
    .ORG_Y (ORG_Y),
    .COLOR (COLOR)
  ) u_fetch (
    .clk        (clk),
    .rst        (rst),
    .video_on   (video_on),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .visible    (visible_q),
    .pixels     (pixels),
    .banner_pix (banner_pix),
    .banner_rgb (banner_rgb)
  );

endmodule

// File: tb/tb_record_banner_ctrl.sv
// Scoreboard bench for record_banner_ctrl. The driver issues one raster
// cycle at a time and pushes the expected outputs for every clock edge;
// a monitor on the falling edge pops and compares them. The show sequence
// is modelled as "frames counted since the last new_record".
module tb_record_banner_ctrl;

  localparam int ROWS  = 24;
  localparam int COLS  = 264;
  localparam int ORG_X = 188;
  localparam int ORG_Y = 228;
  localparam int BLINK_FRAMES = 120;
  localparam int BLINK_HALF   = 15;
  localparam int SEQ_FRAMES   = 300;
  localparam logic [11:0] COLOR = 12'hFF0;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 new_record = 1'b0;
  logic                 frame_start = 1'b0;
  logic                 video_on = 1'b0;
  logic [9:0]           pixel_x = '0;
  logic [9:0]           pixel_y = '0;
  logic [ROWS*COLS-1:0] pixels = '0;
  logic                 banner_pix;
  logic [11:0]          banner_rgb;
  logic                 banner_busy;

  record_banner_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .new_record  (new_record),
    .frame_start (frame_start),
    .video_on    (video_on),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .pixels      (pixels),
    .banner_pix  (banner_pix),
    .banner_rgb  (banner_rgb),
    .banner_busy (banner_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit pix;
    bit busy;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   pops  = 0;

  // Reference model state.
  bit m_active = 1'b0;
  int m_n      = 0;
  bit pend_v   = 1'b0;
  int pend_idx = 0;

  function automatic bit vis_of(input int n);
    if (n < BLINK_FRAMES) return ((n / BLINK_HALF) % 2) == 0;
    return 1'b1;
  endfunction

  // Called right after each rising edge with the inputs that edge sampled.
  task automatic model_edge();
    bit   vis_now;
    exp_t e;
    int   x, y;
    vis_now = m_active && vis_of(m_n);
    e.pix   = !rst && pend_v && vis_now && pixels[pend_idx];

    if (rst) begin
      m_active = 1'b0;
      m_n      = 0;
    end else if (new_record) begin
      m_active = 1'b1;
      m_n      = 0;
    end else if (frame_start && m_active) begin
      m_n++;
      if (m_n >= SEQ_FRAMES) begin
        m_active = 1'b0;
        m_n      = 0;
      end
    end
    e.busy = m_active;
    exp_q.push_back(e);

    x = int'(pixel_x);
    y = int'(pixel_y);
    if (rst) begin
      pend_v = 1'b0;
    end else begin
      pend_v = video_on && x >= ORG_X && x < ORG_X + COLS &&
               y >= ORG_Y && y < ORG_Y + ROWS;
      pend_idx = pend_v ? (y - ORG_Y) * COLS + (COLS - 1 - (x - ORG_X)) : 0;
    end
  endtask

  task automatic cyc(input int x, input int y, input bit von,
                     input bit nr, input bit fs, input bit r);
    @(negedge clk);
    pixel_x     = 10'(x);
    pixel_y     = 10'(y);
    video_on    = von;
    new_record  = nr;
    frame_start = fs;
    rst         = r;
    @(posedge clk);
    model_edge();
  endtask

  task automatic rand_cyc(input bit nr, input bit fs);
    cyc($urandom_range(ORG_X + COLS + 4, ORG_X - 4),
        $urandom_range(ORG_Y + ROWS + 3, ORG_Y - 3),
        $urandom_range(9, 0) != 0, nr, fs, 1'b0);
  endtask

  task automatic frame();
    rand_cyc(1'b0, 1'b1);
    repeat (23) rand_cyc(1'b0, 1'b0);
  endtask

  // Monitor: one expected entry per clock edge.
  always @(negedge clk) begin
    exp_t e;
    logic [11:0] rgb_exp;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      pops++;
      rgb_exp = e.pix ? COLOR : 12'h000;
      total += 3;
      if (banner_pix !== e.pix) begin
        bad++;
        if (bad < 30) $display("FAIL banner_pix t=%0t got=%b want=%b", $time, banner_pix, e.pix);
      end
      if (banner_rgb !== rgb_exp) begin
        bad++;
        if (bad < 30) $display("FAIL banner_rgb t=%0t got=%h want=%h", $time, banner_rgb, rgb_exp);
      end
      if (banner_busy !== e.busy) begin
        bad++;
        if (bad < 30) $display("FAIL banner_busy t=%0t got=%b want=%b", $time, banner_busy, e.busy);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < ROWS * COLS; i += 32) begin
      logic [31:0] w;
      w = $urandom;
      for (int b = 0; b < 32; b++)
        if (i + b < ROWS * COLS) pixels[i + b] = w[b];
    end
    pixels[COLS - 1] = 1'b1;            // row 0, column 0
    pixels[(ROWS - 1) * COLS] = 1'b1;   // last row, last column

    // 1: reset with toggling inputs, then idle frames show nothing.
    cyc(ORG_X, ORG_Y, 1'b1, 1'b1, 1'b1, 1'b1);
    cyc(ORG_X + 5, ORG_Y + 2, 1'b1, 1'b1, 1'b0, 1'b1);
    repeat (5) frame();

    // 2: start, then window edges.
    cyc(0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(ORG_X, ORG_Y, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(ORG_X - 1, ORG_Y, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(ORG_X + COLS, ORG_Y, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(ORG_X + COLS - 1, ORG_Y + ROWS - 1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(ORG_X, ORG_Y + ROWS, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(ORG_X, ORG_Y - 1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(ORG_X, ORG_Y, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(ORG_X, ORG_Y, 1'b1, 1'b0, 1'b0, 1'b0);

    // 3: full sequence and beyond.
    repeat (SEQ_FRAMES + 10) frame();

    // 4: restart from HOLD at frame 200.
    cyc(0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (200) frame();
    cyc(ORG_X, ORG_Y, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (40) frame();

    // 5: new_record coincident with frame_start.
    cyc(ORG_X, ORG_Y, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (40) frame();

    // 6: reset mid-blink with the raster on a lit pixel.
    cyc(0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) frame();
    cyc(ORG_X, ORG_Y, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(ORG_X, ORG_Y, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(ORG_X, ORG_Y, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(ORG_X, ORG_Y, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) frame();

    @(negedge clk);
    #1;
    total++;
    if (pops < 100 || exp_q.size() > 1) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d/%0d want>=100/<=1", pops, exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
